// File: rtl/ulaw_stream_encoder.sv
// Multi-lane pipelined signed fixed-point to G.711 mu-law encoder with a valid/ready stream interface.
// Stage 1 scales, clamps and biases each lane; stage 2 encodes and drives the output register.
module ulaw_stream_encoder #(
   parameter int unsigned LANES = 4,
   parameter int unsigned IN_W  = 16,
   parameter int unsigned SHIFT = 2,
   parameter int unsigned CNT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [LANES*IN_W-1:0]   in_data,
   input  logic                    in_last,
   input  logic                    ulaw_inv,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LANES*8-1:0]      out_data,
   output logic                    out_last,
   input  logic                    sat_clr,
   output logic [CNT_W-1:0]        sat_cnt
);

   localparam int unsigned MAG_W  = 13;
   localparam int unsigned BIAS_W = 14;
   localparam int unsigned CODE_W = 8;

   localparam logic signed [IN_W-1:0] POS_LIM = IN_W'(8191);
   localparam logic signed [IN_W-1:0] NEG_LIM = -POS_LIM;
   localparam logic [BIAS_W-1:0]      BIAS    = BIAS_W'(33);
   localparam logic [BIAS_W-1:0]      MAG_MAX = BIAS_W'(8191);

   // Segment = position of the leading one in b[12:5]; mantissa = the 4 bits below it.
   function automatic logic [CODE_W-1:0] encode(input logic sign, input logic [MAG_W-1:0] b,
                                                input logic inv);
      logic [2:0]        e;
      logic [3:0]        mant;
      logic [CODE_W-1:0] code;
      e = 3'd0;
      for (int k = 0; k < 8; k++) begin
         if (b[k+5]) e = 3'(k);
      end
      mant = 4'(b >> (4'(e) + 4'd1));
      code = {sign, e, mant};
      return inv ? ~code : code;
   endfunction

   logic                              s2_ready_c;
   logic                              accept_c;
   logic [LANES-1:0]                  sign_c;
   logic [LANES-1:0]                  clamp_c;
   logic [LANES-1:0][MAG_W-1:0]       bias_c;
   logic [LANES-1:0][CODE_W-1:0]      enc_c;

   logic                              s1_valid;
   logic                              s1_inv;
   logic                              s1_last;
   logic [LANES-1:0]                  s1_sign;
   logic [LANES-1:0][MAG_W-1:0]       s1_b;

   assign s2_ready_c = ~out_valid | out_ready;
   assign in_ready   = ~s1_valid | s2_ready_c;
   assign accept_c   = in_valid & in_ready;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic signed [IN_W-1:0] lane;
      logic signed [IN_W-1:0] shifted;
      logic signed [IN_W-1:0] clamped;
      logic [MAG_W-1:0]       mag;
      logic [BIAS_W-1:0]      biased;
      logic                   range_clamp;
      logic                   bias_sat;

      // Scale, symmetric clamp (-8192 folds to -8191), sign/magnitude split and biasing.
      always_comb begin
         lane        = signed'(in_data[i*IN_W +: IN_W]);
         shifted     = lane >>> SHIFT;
         range_clamp = (shifted > POS_LIM) || (shifted < NEG_LIM);
         if (shifted > POS_LIM) begin
            clamped = POS_LIM;
         end else if (shifted < NEG_LIM) begin
            clamped = NEG_LIM;
         end else begin
            clamped = shifted;
         end
         mag      = MAG_W'(clamped[IN_W-1] ? -clamped : clamped);
         biased   = {1'b0, mag} + BIAS;
         bias_sat = biased > MAG_MAX;
      end

      assign sign_c[i]  = clamped[IN_W-1];
      assign bias_c[i]  = bias_sat ? MAG_W'(8191) : biased[MAG_W-1:0];
      assign clamp_c[i] = range_clamp | bias_sat;
      assign enc_c[i]   = encode(s1_sign[i], s1_b[i], s1_inv);
   end

   // Stage 1: biased magnitudes plus per-beat sideband.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_inv   <= 1'b0;
         s1_last  <= 1'b0;
         s1_sign  <= '0;
         s1_b     <= '0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_inv  <= ulaw_inv;
            s1_last <= in_last;
            s1_sign <= sign_c;
            s1_b    <= bias_c;
         end
      end
   end

   // Stage 2: encoded output register, held while the consumer stalls.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
      end else if (s2_ready_c) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_data <= enc_c;
            out_last <= s1_last;
         end
      end
   end

   // Saturating count of accepted beats with any clamped lane; clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sat_cnt <= '0;
      end else if (sat_clr) begin
         sat_cnt <= '0;
      end else if (accept_c && (|clamp_c) && (sat_cnt != '1)) begin
         sat_cnt <= sat_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_ulaw_stream_encoder.sv
// Scoreboard bench for ulaw_stream_encoder: accepted beats push reference codes,
// a negedge monitor pops and compares each delivered beat and tracks sat_cnt.
module tb_ulaw_stream_encoder;

   localparam int unsigned LANES = 4;
   localparam int unsigned IN_W  = 16;
   localparam int unsigned SHIFT = 2;
   localparam int unsigned CNT_W = 16;
   localparam int unsigned DIN   = LANES*IN_W;
   localparam int unsigned DOUT  = LANES*8;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [DIN-1:0]    in_data;
   logic              in_last;
   logic              ulaw_inv;
   logic              out_valid;
   logic              out_ready;
   logic [DOUT-1:0]   out_data;
   logic              out_last;
   logic              sat_clr;
   logic [CNT_W-1:0]  sat_cnt;

   always #5 clk = ~clk;

   ulaw_stream_encoder #(.LANES(LANES), .IN_W(IN_W), .SHIFT(SHIFT), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .ulaw_inv(ulaw_inv),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
      .sat_clr(sat_clr), .sat_cnt(sat_cnt)
   );

   typedef struct {
      logic [DOUT-1:0] data;
      logic            last;
   } beat_t;

   beat_t            exp_q[$];
   int               checks = 0;
   int               errors = 0;
   int               n_out  = 0;
   logic [CNT_W-1:0] exp_sat = '0;
   logic             stall_prev = 1'b0;
   logic [DOUT-1:0]  held_data = '0;
   logic             held_last = 1'b0;

   // Reference: plain integer arithmetic on the mu-law rules.
   function automatic logic [7:0] ref_code(input int x, input logic inv);
      int s, m, b, e, mant, code;
      s = x >>> SHIFT;
      if (s > 8191)  s = 8191;
      if (s < -8191) s = -8191;
      m = (s < 0) ? -s : s;
      b = m + 33;
      if (b > 8191) b = 8191;
      e = 0;
      while ((b >> (e + 6)) != 0) e++;
      mant = (b >> (e + 1)) % 16;
      code = ((s < 0) ? 128 : 0) + e*16 + mant;
      if (inv) code = 255 - code;
      return 8'(code);
   endfunction

   function automatic bit ref_clamp(input int x);
      int s;
      s = x >>> SHIFT;
      if (s > 8191 || s < -8191) return 1'b1;
      return ((s < 0 ? -s : s) + 33) > 8191;
   endfunction

   function automatic int lane_val(input logic [DIN-1:0] d, input int i);
      logic signed [IN_W-1:0] v;
      v = d[i*IN_W +: IN_W];
      return int'(v);
   endfunction

   function automatic logic [DIN-1:0] rand_beat();
      logic [DIN-1:0] d;
      int v;
      for (int i = 0; i < LANES; i++) begin
         case ($urandom_range(0, 4))
            0:       v = int'($urandom_range(0, 65535)) - 32768;
            1:       v = int'($urandom_range(0, 800)) - 400;
            2:       v = $urandom_range(0, 1) ? 32767 - int'($urandom_range(0, 150))
                                              : -32768 + int'($urandom_range(0, 150));
            3:       v = ($urandom_range(0, 1) ? 1 : -1) * (32620 + int'($urandom_range(0, 30)));
            default: v = int'($urandom_range(0, 4000)) - 2000;
         endcase
         d[i*IN_W +: IN_W] = IN_W'(v);
      end
      return d;
   endfunction

   // Monitor/scoreboard: everything sampled at negedge, mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         exp_sat    = '0;
         stall_prev = 1'b0;
      end else begin
         logic [DOUT-1:0] want;
         bit              clampd;
         beat_t           b;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_out: got data %h with no beat outstanding", out_data);
            end else begin
               b = exp_q.pop_front();
               n_out++;
               if (out_data !== b.data || out_last !== b.last) begin
                  errors++;
                  $display("FAIL out_beat: got %h last %0b, want %h last %0b",
                           out_data, out_last, b.data, b.last);
               end
            end
         end
         if (stall_prev) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== held_data || out_last !== held_last) begin
               errors++;
               $display("FAIL stall_hold: got valid %0b data %h last %0b, want valid 1 data %h last %0b",
                        out_valid, out_data, out_last, held_data, held_last);
            end
         end
         stall_prev = out_valid && !out_ready;
         held_data  = out_data;
         held_last  = out_last;

         checks++;
         if (sat_cnt !== exp_sat) begin
            errors++;
            $display("FAIL sat_cnt: got %0d want %0d", sat_cnt, exp_sat);
         end

         clampd = 1'b0;
         if (in_valid && in_ready) begin
            for (int i = 0; i < LANES; i++) begin
               want[i*8 +: 8] = ref_code(lane_val(in_data, i), ulaw_inv);
               clampd |= ref_clamp(lane_val(in_data, i));
            end
            b.data = want;
            b.last = in_last;
            exp_q.push_back(b);
         end
         if (sat_clr) exp_sat = '0;
         else if (in_valid && in_ready && clampd && exp_sat != '1) exp_sat = exp_sat + CNT_W'(1);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask

   task automatic send_one(input logic [DIN-1:0] d, input logic inv, input logic last);
      in_valid  = 1'b1;
      in_data   = d;
      ulaw_inv  = inv;
      in_last   = last;
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_last   = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [DOUT-1:0] want,
                             input logic [CNT_W-1:0] want_sat);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s_timeout: got no out_valid within 8 cycles, want one", name);
      end else begin
         check({name, "_data"}, 64'(out_data), 64'(want));
         check({name, "_sat"}, 64'(sat_cnt), 64'(want_sat));
      end
   endtask

   logic [DIN-1:0] base_beat;
   logic [DIN-1:0] neg_beat;

   initial begin
      int n0;
      logic [DOUT-1:0] snap;
      bit acc;
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; ulaw_inv = 1'b0;
      out_ready = 1'b0; sat_clr = 1'b0;
      base_beat = {16'h7FFF, 16'hFE70, 16'h0190, 16'h0000};
      neg_beat  = {16'h0000, 16'h0000, 16'h0000, 16'h8000};

      repeat (3) tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_out_data", 64'(out_data), 64'd0);
      check("rst_out_last", 64'(out_last), 64'd0);
      check("rst_sat_cnt", 64'(sat_cnt), 64'd0);
      rst = 1'b0;
      tick();
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // Known vectors: inverted, raw, and the -8192 fold.
      send_one(base_beat, 1'b1, 1'b0);
      expect_out("vec_inv", 32'h805FDFFF, CNT_W'(1));
      send_one(base_beat, 1'b0, 1'b0);
      expect_out("vec_raw", 32'h7FA02000, CNT_W'(2));
      send_one(neg_beat, 1'b0, 1'b1);
      expect_out("vec_neg", 32'h000000FF, CNT_W'(3));
      check("vec_neg_last", 64'(out_last), 64'd1);
      repeat (3) tick();

      // Back-to-back burst with last on the final beat.
      n0 = n_out;
      out_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         in_valid = 1'b1; in_data = rand_beat(); ulaw_inv = 1'($urandom_range(0, 1));
         in_last = (k == 15);
         tick();
      end
      in_valid = 1'b0; in_last = 1'b0;
      repeat (4) tick();
      check("burst_count", 64'(n_out - n0), 64'd16);

      // Stall: two beats fill the pipe, then in_ready drops and output holds.
      out_ready = 1'b0; in_valid = 1'b1; in_data = rand_beat(); ulaw_inv = 1'b0;
      snap = '0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("stall_in_ready_%0d", c), 64'(in_ready), (c < 2) ? 64'd1 : 64'd0);
         if (c == 2) snap = out_data;
         if (c == 4) check("stall_data_held", 64'(out_data), 64'(snap));
         acc = in_ready;
         @(posedge clk); #1;
         if (acc) in_data = rand_beat();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (5) tick();
      check("stall_drained", 64'(exp_q.size()), 64'd0);

      // Random traffic with random backpressure and occasional clears.
      for (int k = 0; k < 400; k++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         sat_clr   = ($urandom_range(0, 15) == 0);
         ulaw_inv  = 1'($urandom_range(0, 1));
         in_last   = 1'($urandom_range(0, 1));
         in_data   = rand_beat();
         tick();
      end
      in_valid = 1'b0; sat_clr = 1'b0; out_ready = 1'b1; in_last = 1'b0;
      repeat (5) tick();
      check("random_drained", 64'(exp_q.size()), 64'd0);

      // Async reset with two beats in flight.
      in_valid = 1'b1; in_data = rand_beat(); tick();
      in_data = rand_beat(); tick();
      in_valid = 1'b0;
      #1 rst = 1'b1;
      #1 check("async_rst_out_valid", 64'(out_valid), 64'd0);
      repeat (2) tick();
      rst = 1'b0;
      tick();
      send_one(base_beat, 1'b1, 1'b0);
      expect_out("post_rst", 32'h805FDFFF, CNT_W'(1));
      repeat (3) tick();
      check("post_rst_drained", 64'(exp_q.size()), 64'd0);

      // Saturation: preload to all-ones, then clear racing an increment.
      in_valid = 1'b1; in_data = {LANES{16'h7FFF}}; out_ready = 1'b1;
      repeat ((1 << CNT_W) + 2) tick();
      in_valid = 1'b0;
      @(negedge clk);
      check("sat_hold_max", 64'(sat_cnt), 64'((1 << CNT_W) - 1));
      @(posedge clk); #1;
      in_valid = 1'b1; sat_clr = 1'b1;
      tick();
      in_valid = 1'b0; sat_clr = 1'b0;
      @(negedge clk);
      check("sat_clr_priority", 64'(sat_cnt), 64'd0);
      repeat (4) tick();
      check("final_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got no completion by time limit, want completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/ulaw_stream_encoder.md
Name: ulaw_stream_encoder

Overview:
- Multi-lane, pipelined signed fixed-point to G.711 µ-law compressor with a valid/ready stream interface.
- Sits between the inference datapath's accumulator/activation outputs and the 8-bit storage/export path, so wide fixed-point results can be packed to 8-bit codes at one beat per cycle.
- Generalises the existing 14-bit combinational encoder:
  - parametric input width, pre-scale shift and lane count;
  - symmetric clamping;
  - runtime inversion mode;
  - saturation statistics.

Parameters:
- LANES, 4, number of independent samples encoded per beat.
- IN_W, 16, width of each signed two's-complement input sample (IN_W >= 14).
- SHIFT, 2, arithmetic right shift applied to each sample before encoding (0 <= SHIFT <= IN_W-14).
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept the beat this cycle.
- in_data  in  LANES*IN_W  lane i at [i*IN_W +: IN_W], signed.
- in_last  in  1  end-of-vector marker, carried with the beat.
- ulaw_inv  in  1  1 = G.711 inverted codes, 0 = raw {sign,exp,mant}; sampled with the beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  LANES*8  lane i code at [i*8 +: 8].
- out_last  out  1  in_last delayed with its beat.
- sat_clr  in  1  synchronous clear of sat_cnt.
- sat_cnt  out  CNT_W  count of accepted beats in which at least one lane clamped.

Behaviour:
- Reset (asynchronous): both stage valids = 0, out_valid = 0, out_data = 0, out_last = 0, sat_cnt = 0. in_ready = 1 once reset deasserts.
  - Reset mid-stream drops all in-flight beats; no partial output.
- Pipeline: 2 register stages (S1 scale/clamp/bias, S2 encode/output).
  - Accept when in_valid & in_ready; out_valid rises 2 cycles later if not stalled.
  - Throughput: 1 beat/cycle.
- Handshake:
  - in_ready = ~(S1.valid & S2.valid & ~out_ready), combinational from out_ready.
  - Each stage advances when its successor is empty or advancing.
  - out_data/out_last are held stable while out_valid & ~out_ready.
  - No beat is dropped or duplicated.
  - in_data is don't-care when in_valid = 0.
- S1, per lane:
  - s = in_lane >>> SHIFT.
  - Clamp s to [-8191, +8191]; note -8192 clamps to -8191.
  - sign = (s < 0).
  - m = |s| (13 bits).
  - b = m + 33; if b > 8191 then b = 8191.
  - A lane "clamps" if the range clamp or the bias saturation is active.
- S2, per lane:
  - e = index of the highest set bit of b within bits 12..5, minus 5 (0..7). Bit 5 or above is always set because b >= 33.
  - mant = b[e+4 : e+1].
  - code = {sign, e[2:0], mant[3:0]}.
  - out = ulaw_inv ? ~code : code.
- sat_cnt:
  - Increments by 1 when a beat with any clamped lane is accepted into S1.
  - Saturates at all-ones, no wrap.
  - sat_clr has priority: the counter is 0 the next cycle, and a simultaneous increment is discarded.
- Lanes are fully independent; ulaw_inv and in_last travel with their beat through both stages.

Test Plan:
- IN_W=16, SHIFT=2, ulaw_inv=1; lanes {0, 400, -400, 32767} -> out lanes {0xFF, 0xDF, 0x5F, 0x80} two cycles after accept; sat_cnt = 1.
- Same data with ulaw_inv=0 -> {0x00, 0x20, 0xA0, 0x7F}. Lane -32768 (-8192 after shift) -> 0xFF raw, i.e. clamped to -8191; sat_cnt increments.
- Back-to-back 16 beats with out_ready=1 -> 16 outputs on consecutive cycles, in order. out_last is asserted only on the beat that carried in_last.
- Stall: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 beats buffered, in_ready=0 from the 3rd cycle, out_data held constant. Release -> all beats delivered without loss.
- sat_clr asserted in the same cycle as an accepted clamping beat -> sat_cnt = 0. Preload via 2^CNT_W - 1 clamping beats -> sat_cnt holds at all-ones.
- Assert rst asynchronously with 2 beats in flight -> out_valid = 0 immediately. After release, the first new beat emerges with correct data and none of the old beats appear.
